// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: PC generation, single-outstanding imem requests,
// a prefetch FIFO toward decode, and redirect with flush.
package simple_processor_pkg;
  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 16;
endpackage

module instr_fetch_unit #(
  parameter int ADDR_WIDTH = simple_processor_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
  parameter int PC_STEP    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic [ADDR_WIDTH-1:0] boot_addr_i,
  input  logic                  en_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  imem_ack_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] instr_pc_o,
  input  logic                  instr_ready_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP_C  = ADDR_WIDTH'(PC_STEP);

  typedef enum logic [1:0] {BOOT, IDLE, REQ, DROP} state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  entry_t mem [FIFO_DEPTH];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  req_q, req_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      wptr_q, rptr_q;

  logic                  ack, flush, push, pop, room;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  entry_t                head;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    ack   = imem_ack_i && req_q;
    flush = redirect_i && (state_q != BOOT);
    pop   = instr_valid_o && instr_ready_i && !flush;
    push  = (state_q == REQ) && ack && !flush;

    count_d = flush ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
    room    = en_i && (count_d < DEPTH_C);

    // Address of the next fetch: redirect target, sequential successor, or current pc.
    if (flush)               fetch_pc = redirect_addr_i;
    else if (state_q == REQ) fetch_pc = addr_q + STEP_C;
    else                     fetch_pc = pc_q;

    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;

    unique case (state_q)
      BOOT: begin
        pc_d    = boot_addr_i;
        state_d = IDLE;
      end
      IDLE: begin
        pc_d = fetch_pc;
        if (!flush && en_i && (count_q < DEPTH_C)) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack) begin
          pc_d = fetch_pc;
          if (room) begin
            addr_d = fetch_pc;
          end else begin
            req_d   = 1'b0;
            state_d = IDLE;
          end
        end else if (flush) begin
          pc_d    = fetch_pc;
          state_d = DROP;
        end
      end
      DROP: begin
        // The stale request stays on the bus; its data is thrown away on ack.
        pc_d = fetch_pc;
        if (ack) begin
          if (room) begin
            addr_d  = fetch_pc;
            state_d = REQ;
          end else begin
            req_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= BOOT;
      pc_q    <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wptr_q  <= flush ? '0 : wptr_q + PTR_W'(push);
      rptr_q  <= flush ? '0 : rptr_q + PTR_W'(pop);
    end
  end

  // NOTE: FIFO storage has no reset; the head outputs are gated by valid instead.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wptr_q].pc    <= addr_q;
      mem[wptr_q].instr <= imem_rdata_i;
    end
  end

  assign head          = mem[rptr_q];
  assign instr_valid_o = (count_q != '0);
  assign instr_o       = instr_valid_o ? head.instr : '0;
  assign instr_pc_o    = instr_valid_o ? head.pc    : '0;
  assign imem_req_o    = req_q;
  assign imem_addr_o   = addr_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized
// run scored against a program-order model of the delivered instruction stream.
module tb_instr_fetch_unit;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          arst_n;
  logic [AW-1:0] boot_addr;
  logic          en;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata;
  logic          imem_ack;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_ready;

  instr_fetch_unit #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PC_STEP(2), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i          (clk),
    .arst_ni        (arst_n),
    .boot_addr_i    (boot_addr),
    .en_i           (en),
    .redirect_i     (redirect),
    .redirect_addr_i(redirect_addr),
    .imem_req_o     (imem_req),
    .imem_addr_o    (imem_addr),
    .imem_rdata_i   (imem_rdata),
    .imem_ack_i     (imem_ack),
    .instr_valid_o  (instr_valid),
    .instr_o        (instr),
    .instr_pc_o     (instr_pc),
    .instr_ready_i  (instr_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int errors = 0;

  // Model of the program-order stream seen by decode.
  int            occ;        // entries the FIFO should hold
  logic [AW-1:0] exp_pc;     // next PC decode should receive
  logic          stale;      // outstanding request belongs to a flushed stream
  logic          prev_req, prev_acc;
  logic [AW-1:0] prev_addr;
  int            delivered;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a ^ 16'h5A3C;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_init(input logic [AW-1:0] boot);
    occ       = 0;
    exp_pc    = boot;
    stale     = 1'b0;
    prev_req  = 1'b0;
    prev_acc  = 1'b0;
    prev_addr = '0;
  endtask

  // Entered just after a falling edge: score current outputs, apply inputs, advance one cycle.
  task automatic cycle(input logic ack, input logic rdy, input logic enable,
                       input logic redir, input logic [AW-1:0] raddr);
    logic acc, pop;
    check("valid_vs_occupancy", instr_valid, occ != 0);
    if (prev_req && !prev_acc) begin
      check("req_held_until_ack", imem_req, 1'b1);
      check("addr_held_until_ack", imem_addr, prev_addr);
    end
    acc = imem_req && ack;
    pop = instr_valid && rdy && !redir;
    if (pop) begin
      check("head_pc_order", instr_pc, exp_pc);
      check("head_instr_data", instr, mem_word(exp_pc));
      exp_pc = exp_pc + 16'd2;
      delivered++;
    end
    if (redir) begin
      occ    = 0;
      exp_pc = raddr;
      stale  = imem_req && !ack;
    end else begin
      if (acc) begin
        if (stale) stale = 1'b0;
        else begin
          check("push_not_full", occ < DEPTH, 1'b1);
          occ++;
        end
      end
      if (pop) occ--;
    end
    prev_req  = imem_req;
    prev_acc  = acc;
    prev_addr = imem_addr;

    imem_ack      = ack;
    imem_rdata    = imem_req ? mem_word(imem_addr) : DW'($urandom);
    instr_ready   = rdy;
    en            = enable;
    redirect      = redir;
    redirect_addr = raddr;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Assert reset (checking outputs clear at once), release, then check BOOT/IDLE timing.
  task automatic do_reset(input logic [AW-1:0] boot);
    arst_n      = 1'b0;
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    en          = 1'b1;
    #1;
    check("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, 16'h0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_instr", instr, 16'h0);
    check("rst_pc", instr_pc, 16'h0);
    boot_addr = boot;
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    model_init(boot);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    check("boot_no_req", imem_req, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    check("first_req", imem_req, 1'b1);
    check("first_req_addr", imem_addr, boot);
  endtask

  initial begin
    int acks;
    logic [AW-1:0] t;
    arst_n = 1'b0; boot_addr = '0; en = 1'b0; redirect = 1'b0; redirect_addr = '0;
    imem_rdata = '0; imem_ack = 1'b0; instr_ready = 1'b0;
    @(negedge clk);

    // Boot and sequential fetch with immediate acks.
    do_reset(16'h0100);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    check("b2b_addr_0102", imem_addr, 16'h0102);
    check("valid_after_ack", instr_valid, 1'b1);
    check("head_pc_0100", instr_pc, 16'h0100);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    check("b2b_addr_0104", imem_addr, 16'h0104);
    check("head_pc_0102", instr_pc, 16'h0102);

    // Backpressure: FIFO fills to depth, then requests stop; drain resumes fetch.
    do_reset(16'h1000);
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      if (imem_req) acks++;
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
    end
    check("full_ack_count", acks, DEPTH);
    check("full_req_low", imem_req, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_order", instr_pc, 16'h1000 + 16'(2 * i));
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    end
    for (int i = 0; i < 6 && !imem_req; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    check("resume_req", imem_req, 1'b1);
    check("resume_addr", imem_addr, 16'h1008);

    // Redirect during a delayed request.
    do_reset(16'h0200);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'h0800);
    for (int i = 0; i < 2; i++) begin
      check("drop_addr_held", imem_addr, 16'h0200);
      check("drop_fifo_empty", instr_valid, 1'b0);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    end
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    check("after_drop_req", imem_req, 1'b1);
    check("after_drop_addr", imem_addr, 16'h0800);
    check("drop_data_discarded", instr_valid, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
    check("redirect_target_delivered", instr_pc, 16'h0800);

    // Redirect in the same cycle as the ack.
    do_reset(16'h0300);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'h0400);
    check("coinc_next_addr", imem_addr, 16'h0400);
    check("coinc_not_presented", instr_valid, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
    check("coinc_head_pc", instr_pc, 16'h0400);
    check("coinc_head_instr", instr, mem_word(16'h0400));

    // PC wrap-around.
    do_reset(16'hFFFE);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    check("wrap_addr", imem_addr, 16'h0000);
    check("wrap_head_pc", instr_pc, 16'hFFFE);

    // Reset while a request is pending and two entries are buffered.
    do_reset(16'h0500);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
    check("pre_reset_req", imem_req, 1'b1);
    check("pre_reset_addr", imem_addr, 16'h0504);
    check("pre_reset_valid", instr_valid, 1'b1);
    do_reset(16'h0600);

    // Randomized traffic: stray acks, backpressure, enable gaps and redirects.
    t = 16'($urandom) & 16'hFFFE;
    do_reset(t);
    delivered = 0;
    for (int i = 0; i < 1500; i++) begin
      logic a, r, e, d;
      a = imem_req ? ($urandom_range(2) != 0) : ($urandom_range(3) == 0);
      r = ($urandom_range(3) != 0);
      e = ($urandom_range(7) != 0);
      d = ($urandom_range(19) == 0);
      t = 16'($urandom) & 16'hFFFE;
      cycle(a, r, e, d, t);
    end
    for (int i = 0; i < 20; i++) cycle(imem_req, 1'b1, 1'b1, 1'b0, 16'h0);
    check("random_liveness", delivered > 100, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Parametrised instruction fetch front-end for the simple processor.
- Generates the program counter, starting from a boot address.
- Issues single-outstanding requests on the instruction memory req/ack bus.
- Buffers returned instructions with their PC in a prefetch FIFO.
- Presents the FIFO head to decode over a valid/ready handshake.
- Supports a redirect (branch/jump) input that flushes the FIFO.

Parameters:
ADDR_WIDTH, simple_processor_pkg::ADDR_WIDTH, PC and memory address width
DATA_WIDTH, simple_processor_pkg::DATA_WIDTH, instruction/data bus width
PC_STEP, 2, PC increment per fetched instruction
FIFO_DEPTH, 4, prefetch entries; power of two, >= 2

Ports:
clk_i  in  1  global synchronous clock
arst_ni  in  1  asynchronous active-low reset
boot_addr_i  in  ADDR_WIDTH  first PC after reset
en_i  in  1  fetch enable; when low, no new requests are issued
redirect_i  in  1  single-cycle pulse: flush and restart fetch at redirect_addr_i
redirect_addr_i  in  ADDR_WIDTH  redirect target PC
imem_req_o  out  1  instruction request active
imem_addr_o  out  ADDR_WIDTH  request address
imem_rdata_i  in  DATA_WIDTH  instruction data, valid with ack
imem_ack_i  in  1  request completed
instr_valid_o  out  1  FIFO head valid
instr_o  out  DATA_WIDTH  FIFO head instruction
instr_pc_o  out  ADDR_WIDTH  FIFO head PC
instr_ready_i  in  1  decode accepts head

Behaviour:
- Reset: clock is clk_i; reset is arst_ni, asynchronous and active-low.
  - While reset is asserted: imem_req_o=0, imem_addr_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0, pc=0, FIFO empty, state=BOOT.
  - Asserting reset mid-transaction aborts it immediately.
- FSM states: BOOT, IDLE, REQ, DROP.
  - BOOT: lasts exactly one cycle after reset release; pc<=boot_addr_i; go to IDLE.
  - IDLE: if en_i=1 and count<FIFO_DEPTH, then next cycle imem_req_o=1 and imem_addr_o=pc; go to REQ.
  - REQ: imem_req_o and imem_addr_o are held stable until imem_ack_i.
    - On ack: push {imem_addr_o, imem_rdata_i}; pc<=imem_addr_o+PC_STEP.
    - Back-to-back: if en_i=1 and post-push/pop count<FIFO_DEPTH, next cycle issue the request at the new pc and stay in REQ.
    - Otherwise drop imem_req_o and go to IDLE.
  - DROP: the request stays asserted at the old address until ack; the returned data is discarded; then issue the request at pc as in IDLE.
- Handshake rules:
  - A request is never withdrawn or re-addressed before its ack.
  - At most one request is outstanding.
  - Ack is ignored when imem_req_o=0.
- Latency: ack in cycle N -> instr_valid_o=1 in cycle N+1 (FIFO previously empty).
- FIFO behaviour:
  - instr_valid_o = (count != 0); instr_o and instr_pc_o are driven from the head entry.
  - Pop when instr_valid_o && instr_ready_i.
  - Push and pop may occur in the same cycle; count is unchanged.
  - Requests are gated so a push never targets a full FIFO.
  - Reads and writes wrap modulo FIFO_DEPTH.
- Redirect (redirect_i=1), effective from the next cycle:
  - FIFO flushed, instr_valid_o=0, pc<=redirect_addr_i.
  - Any pop in the same cycle is ignored.
  - In REQ without ack this cycle: go to DROP.
  - In REQ with ack this cycle: the data is discarded (not pushed), and the next request uses redirect_addr_i.
  - In IDLE or DROP: pc is updated only; DROP continues to wait for its ack.
  - Redirect in BOOT is ignored.
- en_i low: no new requests; an outstanding request completes normally.
- Arithmetic: PC addition is modulo 2^ADDR_WIDTH; wrap from all-ones is silent.

Test Plan:
- Boot: boot_addr_i=0x0100, en_i=1, ack one cycle after each req, ready=1 -> request addresses 0x0100, 0x0102, 0x0104; instr_pc_o matches each address; instr_valid_o rises the cycle after the first ack.
- Backpressure: instr_ready_i=0, immediate acks, FIFO_DEPTH=4 -> exactly 4 acks, imem_req_o then stays 0; raise ready -> entries drain in order and fetching resumes at pc=base+8.
- Redirect mid-request: req at 0x0200 with ack delayed 3 cycles; redirect_i=1 to 0x0800 in the 1st wait cycle -> imem_addr_o stays 0x0200 until ack, data not delivered, next req at 0x0800, FIFO empty in between.
- Redirect coincident with ack: ack for 0x0300 in the same cycle as redirect to 0x0400 -> 0x0300 is never presented; next req at 0x0400.
- Wrap-around: ADDR_WIDTH=16, boot_addr_i=0xFFFE -> requests 0xFFFE then 0x0000.
- Reset mid-operation: assert arst_ni low while req is pending with 2 FIFO entries -> all outputs 0 immediately; after release, first req at boot_addr_i exactly 2 cycles later (BOOT, IDLE).
